// File: rtl/instr_fetch_reg.sv
// Fetch stage and instruction register of the multi-cycle processor.
// Holds the PC and runs a req/ack read to instruction memory with a bounded wait.
// The returned word is latched into the IR, which is sliced into the fields that
// feed the immediate extender and the register file.

module instr_fetch_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [5:0]  ZEXT_OP0 = 6'h0C,
    parameter logic [5:0]  ZEXT_OP1 = 6'h0D
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_start,
    input  logic        i_pc_load,
    input  logic [31:0] i_pc_in,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic        o_busy,
    output logic [31:0] o_ir,
    output logic        o_ir_valid,
    output logic        o_fetch_err,
    output logic [5:0]  o_opcode,
    output logic [3:0]  o_rd,
    output logic [3:0]  o_rs1,
    output logic [3:0]  o_rs2,
    output logic [13:0] o_imm14,
    output logic        o_ext_ctrl
);

    // Counter holds 0..TIMEOUT-1; the last value marks the final REQ cycle allowed.
    localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic {
        StIdle,
        StReq
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [31:0]     r_pc;
    logic [31:0]     w_pc_d;
    logic [31:0]     r_ir;
    logic [31:0]     w_ir_d;
    logic            r_ir_valid;
    logic            w_ir_valid_d;
    logic            r_req;
    logic            w_req_d;
    logic            r_fetch_err;
    logic            w_fetch_err_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;

    // PC loads are word aligned, so the two low address bits are dropped.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^i_pc_in[1:0];

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and datapath updates for the fetch handshake.
    always_comb begin
        w_state_d     = r_state;
        w_pc_d        = r_pc;
        w_ir_d        = r_ir;
        w_ir_valid_d  = r_ir_valid;
        w_req_d       = r_req;
        w_fetch_err_d = 1'b0;
        w_cnt_d       = r_cnt;

        unique case (r_state)
            StIdle: begin
                // A simultaneous load and start fetch from the freshly loaded PC,
                // since the request address is the PC register itself.
                if (i_pc_load) begin
                    w_pc_d = {i_pc_in[31:2], 2'b00};
                end
                if (i_fetch_start) begin
                    w_state_d    = StReq;
                    w_req_d      = 1'b1;
                    w_ir_valid_d = 1'b0;
                    w_cnt_d      = '0;
                end
            end
            StReq: begin
                // Ack is checked first so it wins over a timeout in the same cycle.
                if (i_imem_ack) begin
                    w_ir_d       = i_imem_rdata;
                    w_ir_valid_d = 1'b1;
                    w_pc_d       = r_pc + 32'd4;
                    w_req_d      = 1'b0;
                    w_state_d    = StIdle;
                end else if (r_cnt == CntLast) begin
                    w_fetch_err_d = 1'b1;
                    w_req_d       = 1'b0;
                    w_state_d     = StIdle;
                end else begin
                    w_cnt_d = r_cnt + CntOne;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_req_d   = 1'b0;
            end
        endcase
    end

    // Datapath registers: PC, IR, handshake and status flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc        <= RESET_PC;
            r_ir        <= 32'h0;
            r_ir_valid  <= 1'b0;
            r_req       <= 1'b0;
            r_fetch_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pc        <= w_pc_d;
            r_ir        <= w_ir_d;
            r_ir_valid  <= w_ir_valid_d;
            r_req       <= w_req_d;
            r_fetch_err <= w_fetch_err_d;
            r_cnt       <= w_cnt_d;
        end
    end

    assign o_imem_req  = r_req;
    assign o_imem_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_busy      = (r_state == StReq);
    assign o_ir        = r_ir;
    assign o_ir_valid  = r_ir_valid;
    assign o_fetch_err = r_fetch_err;

    // Instruction field decode straight off the IR.
    assign o_opcode = r_ir[31:26];
    assign o_rd     = r_ir[25:22];
    assign o_rs1    = r_ir[21:18];
    assign o_rs2    = r_ir[17:14];
    assign o_imm14  = r_ir[13:0];

    // Logical-immediate opcodes take a zero-extended immediate; all others sign-extend.
    assign o_ext_ctrl = !((o_opcode == ZEXT_OP0) || (o_opcode == ZEXT_OP1));

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Scoreboard bench for instr_fetch_reg: stimulus pushes expected fetch outcomes,
// a monitor pops and compares them when the DUT completes or aborts a fetch.

module tb_instr_fetch_reg;

    logic        clk;
    logic        rst;
    logic        fetch_start;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        busy;
    logic [31:0] ir;
    logic        ir_valid;
    logic        fetch_err;
    logic [5:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [13:0] imm14;
    logic        ext_ctrl;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_err;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [13:0] imm;
        logic        ext;
    } exp_t;

    exp_t sb_q[$];

    instr_fetch_reg #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16),
        .ZEXT_OP0 (6'h0C),
        .ZEXT_OP1 (6'h0D)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fetch_start(fetch_start),
        .i_pc_load    (pc_load),
        .i_pc_in      (pc_in),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .o_pc         (pc),
        .o_busy       (busy),
        .o_ir         (ir),
        .o_ir_valid   (ir_valid),
        .o_fetch_err  (fetch_err),
        .o_opcode     (opcode),
        .o_rd         (rd),
        .o_rs1        (rs1),
        .o_rs2        (rs2),
        .o_imm14      (imm14),
        .o_ext_ctrl   (ext_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ack(input logic [31:0] e_ir, input logic [31:0] e_pc,
                            input logic [5:0] e_op, input logic [3:0] e_rd,
                            input logic [3:0] e_rs1, input logic [3:0] e_rs2,
                            input logic [13:0] e_imm, input logic e_ext);
        exp_t e;
        e.is_err = 1'b0;
        e.ir = e_ir;
        e.pc = e_pc;
        e.op = e_op;
        e.rd = e_rd;
        e.rs1 = e_rs1;
        e.rs2 = e_rs2;
        e.imm = e_imm;
        e.ext = e_ext;
        sb_q.push_back(e);
    endtask

    task automatic push_err(input logic [31:0] e_ir, input logic [31:0] e_pc);
        exp_t e;
        e = '0;
        e.is_err = 1'b1;
        e.ir = e_ir;
        e.pc = e_pc;
        sb_q.push_back(e);
    endtask

    // Monitor: a rising ir_valid is a completed fetch, a fetch_err pulse an aborted one.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && ((ir_valid && !prev_valid) || fetch_err)) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got valid=%b err=%b expected no event",
                             ir_valid, fetch_err);
                end else begin
                    e = sb_q.pop_front();
                    chk("event_kind", {31'b0, fetch_err}, {31'b0, e.is_err});
                    chk("ev_pc", pc, e.pc);
                    chk("ev_ir", ir, e.ir);
                    chk("ev_req_low", {31'b0, imem_req}, 32'd0);
                    if (e.is_err) begin
                        chk("err_ir_valid", {31'b0, ir_valid}, 32'd0);
                    end else begin
                        chk("opcode", {26'b0, opcode}, {26'b0, e.op});
                        chk("rd", {28'b0, rd}, {28'b0, e.rd});
                        chk("rs1", {28'b0, rs1}, {28'b0, e.rs1});
                        chk("rs2", {28'b0, rs2}, {28'b0, e.rs2});
                        chk("imm14", {18'b0, imm14}, {18'b0, e.imm});
                        chk("ext_ctrl", {31'b0, ext_ctrl}, {31'b0, e.ext});
                    end
                end
            end
            prev_valid = ir_valid;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        pc_in       = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ext", {31'b0, ext_ctrl}, 32'd1);
        chk("rst_imm", {18'b0, imm14}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Minimum-latency fetch.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t1_req", {31'b0, imem_req}, 32'd1);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        push_ack(32'h3040_3FF6, 32'h4, 6'h0C, 4'h1, 4'h0, 4'h0, 14'h3FF6, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3040_3FF6;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("t1_valid_latency", {31'b0, ir_valid}, 32'd1);

        // Ack delayed 5 cycles; start/load during REQ are ignored.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_req_hold", {31'b0, imem_req}, 32'd1);
            chk("t2_addr_hold", imem_addr, 32'h4);
            pc_load     = 1'b1;
            pc_in       = 32'h0000_0500;
            fetch_start = 1'b1;
            tick();
        end
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        chk("t2_addr_after", imem_addr, 32'h4);
        push_ack(32'h0440_000A, 32'h8, 6'h01, 4'h1, 4'h0, 4'h0, 14'h000A, 1'b1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0440_000A;
        tick();
        imem_ack = 1'b0;
        chk("t2_pc", pc, 32'h8);

        // PC load and fetch start together.
        pc_load     = 1'b1;
        pc_in       = 32'h0000_0103;
        fetch_start = 1'b1;
        tick();
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        chk("t3_addr", imem_addr, 32'h0000_0100);
        push_ack(32'h3440_0001, 32'h104, 6'h0D, 4'h1, 4'h0, 4'h0, 14'h0001, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3440_0001;
        tick();
        imem_ack = 1'b0;

        // Timeout with no ack.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        push_err(32'h3440_0001, 32'h104);
        for (int i = 0; i < 16; i++) begin
            chk("t4_req_wait", {31'b0, imem_req}, 32'd1);
            chk("t4_no_err_yet", {31'b0, fetch_err}, 32'd0);
            tick();
        end
        chk("t4_err_pulse", {31'b0, fetch_err}, 32'd1);
        chk("t4_req_drop", {31'b0, imem_req}, 32'd0);
        chk("t4_busy_drop", {31'b0, busy}, 32'd0);
        chk("t4_pc_kept", pc, 32'h104);
        chk("t4_ir_valid", {31'b0, ir_valid}, 32'd0);
        tick();
        chk("t4_err_one_cycle", {31'b0, fetch_err}, 32'd0);

        // Ack in the final allowed REQ cycle wins over the timeout.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        repeat (15) tick();
        push_ack(32'h1234_5678, 32'h108, 6'h04, 4'h8, 4'hD, 4'h1, 14'h1678, 1'b1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        chk("t5_no_err", {31'b0, fetch_err}, 32'd0);
        chk("t5_valid", {31'b0, ir_valid}, 32'd1);

        // PC wrap, then spurious ack in IDLE.
        pc_load = 1'b1;
        pc_in   = 32'hFFFF_FFFF;
        tick();
        pc_load = 1'b0;
        chk("t6_pc_loaded", pc, 32'hFFFF_FFFC);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
        push_ack(32'h3000_0000, 32'h0, 6'h0C, 4'h0, 4'h0, 4'h0, 14'h0000, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3000_0000;
        tick();
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        imem_ack = 1'b0;
        chk("t6_spurious_ir", ir, 32'h3000_0000);
        chk("t6_spurious_pc", pc, 32'h0);
        chk("t6_spurious_valid", {31'b0, ir_valid}, 32'd1);
        chk("t6_spurious_req", {31'b0, imem_req}, 32'd0);

        // Asynchronous reset in the middle of a REQ.
        pc_load     = 1'b1;
        pc_in       = 32'h0000_0040;
        fetch_start = 1'b1;
        tick();
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        chk("t7_addr", imem_addr, 32'h40);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t7_req_async", {31'b0, imem_req}, 32'd0);
        chk("t7_pc_async", pc, 32'h0);
        chk("t7_valid_async", {31'b0, ir_valid}, 32'd0);
        chk("t7_busy_async", {31'b0, busy}, 32'd0);
        chk("t7_ir_async", ir, 32'h0);
        tick();
        rst = 1'b0;

        // Normal operation after reset.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t8_addr", imem_addr, 32'h0);
        push_ack(32'h0440_000A, 32'h4, 6'h01, 4'h1, 4'h0, 4'h0, 14'h000A, 1'b1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0440_000A;
        tick();
        imem_ack = 1'b0;
        repeat (3) tick();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
